// File: rtl/comproc_pkg.sv
// ----------------------------------------------------------------------------
// comproc_pkg
// Shared types and constants for the program loader / memory arbiter.
//   ADDR_WIDTH  : default memory byte-address width
//   LOAD_BASE   : default byte address of the first loaded program word
//   END_WORD    : word that ends a load and releases the CPU
//   RELOAD_WORD : word received at run time that restarts a load
//   loader_state_e : loader FSM states
// ----------------------------------------------------------------------------
package comproc_pkg;

    localparam int unsigned ADDR_WIDTH  = 12;
    localparam logic [11:0] LOAD_BASE   = 12'h300;
    localparam logic [15:0] END_WORD    = 16'hFFFF;
    localparam logic [15:0] RELOAD_WORD = 16'hFFFE;

    typedef enum logic [1:0] {
        LOAD_HI,
        LOAD_LO,
        WRITE,
        RUN
    } loader_state_e;

endpackage

// File: rtl/word_assembler.sv
// ----------------------------------------------------------------------------
// word_assembler
// Pairs received bytes into 16-bit words, high byte first. A pending high
// byte is dropped if no further strobe arrives for TIMEOUT_CYC cycles, so a
// lost byte cannot leave the pairing permanently out of step.
// Ports:
//   clk       : clock, rising edge
//   i_byte    : received byte
//   i_strobe  : one-cycle strobe, i_byte valid
//   i_flush   : synchronous clear of byte phase and timeout counter
//   o_word    : {held high byte, i_byte}, meaningful when o_word_v = 1
//   o_word_v  : a word completes this cycle (combinational from i_strobe)
//   o_hi_pend : a high byte is held, waiting for its low byte
// ----------------------------------------------------------------------------
module word_assembler #(
    parameter int unsigned TIMEOUT_CYC = 270000
) (
    input  logic        clk,
    input  logic [7:0]  i_byte,
    input  logic        i_strobe,
    input  logic        i_flush,
    output logic [15:0] o_word,
    output logic        o_word_v,
    output logic        o_hi_pend
);

    localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic             r_hi_pend;
    logic [7:0]       r_hi;
    logic [TMO_W-1:0] r_tmo;

    always_ff @(posedge clk) begin
        if (i_flush) begin
            r_hi_pend <= 1'b0;
            r_tmo     <= '0;
        end else if (i_strobe) begin
            r_tmo     <= '0;
            r_hi_pend <= ~r_hi_pend;
        end else if (r_hi_pend) begin
            if (r_tmo == TMO_LAST) begin
                r_hi_pend <= 1'b0;
                r_tmo     <= '0;
            end else begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
        end
    end

    // Data only; its validity is tracked by r_hi_pend.
    always_ff @(posedge clk) begin
        if (i_strobe && !r_hi_pend) begin
            r_hi <= i_byte;
        end
    end

    assign o_word    = {r_hi, i_byte};
    assign o_word_v  = i_strobe & r_hi_pend & ~i_flush;
    assign o_hi_pend = r_hi_pend;

endmodule

// File: rtl/prog_loader_arb.sv
// ----------------------------------------------------------------------------
// prog_loader_arb
// Loads a program received over the UART into memory while holding the CPU
// in reset, then hands the memory port to the CPU. At run time received words
// are forwarded to the CPU; RELOAD_WORD restarts a load.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   rx_data, rx_data_wr      : received UART byte and its strobe
//   cpu_mem_*, cpu_wr_data   : CPU memory request
//   mem_*, mem_wr_data       : arbitrated memory port
//   cpu_rst                  : CPU held in reset while not in RUN
//   uart_in, uart_in_v       : run-time received word and one-cycle valid
//   load_err                 : sticky, a word arrived after the address wrapped
//   word_cnt                 : words written during the current load
// ----------------------------------------------------------------------------
module prog_loader_arb #(
    parameter int unsigned       ADDR_W      = comproc_pkg::ADDR_WIDTH,
    parameter logic [ADDR_W-1:0] LOAD_BASE   = ADDR_W'(comproc_pkg::LOAD_BASE),
    parameter int unsigned       TIMEOUT_CYC = 270000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_wr,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic              cpu_mem_wr,
    input  logic              cpu_mem_byt,
    input  logic [15:0]       cpu_wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic              mem_byt,
    output logic [15:0]       mem_wr_data,
    output logic              cpu_rst,
    output logic [15:0]       uart_in,
    output logic              uart_in_v,
    output logic              load_err,
    output logic [ADDR_W-2:0] word_cnt
);

    import comproc_pkg::*;

    // Program words are 16-bit, so load addresses are always even.
    localparam logic [ADDR_W-1:0] BASE_ALIGNED = {LOAD_BASE[ADDR_W-1:1], 1'b0};
    localparam logic [ADDR_W-1:0] LAST_ADDR    = {{(ADDR_W-1){1'b1}}, 1'b0};

    loader_state_e     r_state;
    loader_state_e     w_state_d;
    logic [ADDR_W-1:0] r_load_addr;
    logic [ADDR_W-2:0] r_word_cnt;
    logic              r_addr_wrap;
    logic              r_load_err;
    logic [15:0]       r_wr_word;
    logic [15:0]       r_uart_in;
    logic              r_uart_in_v;

    logic [15:0] w_word;
    logic        w_word_v;
    logic        w_hi_pend;
    logic        w_is_end;
    logic        w_is_reload;

    word_assembler #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_word_asm (
        .clk       (clk),
        .i_byte    (rx_data),
        .i_strobe  (rx_data_wr),
        .i_flush   (rst),
        .o_word    (w_word),
        .o_word_v  (w_word_v),
        .o_hi_pend (w_hi_pend)
    );

    assign w_is_end    = w_word_v && (w_word == END_WORD);
    assign w_is_reload = w_word_v && (w_word == RELOAD_WORD);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD_HI;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic. LOAD_HI/LOAD_LO track the assembler's byte phase.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            LOAD_HI: begin
                if (rx_data_wr) w_state_d = LOAD_LO;
            end
            LOAD_LO: begin
                if (w_is_end) begin
                    w_state_d = RUN;
                end else if (w_word_v) begin
                    w_state_d = r_addr_wrap ? LOAD_HI : WRITE;
                end else if (!w_hi_pend) begin
                    w_state_d = LOAD_HI; // high byte timed out
                end
            end
            WRITE: begin
                // A strobe here is already the next word's high byte.
                w_state_d = rx_data_wr ? LOAD_LO : LOAD_HI;
            end
            RUN: begin
                if (w_is_reload) w_state_d = LOAD_HI;
            end
            default: w_state_d = LOAD_HI;
        endcase
    end

    // Load address, word counter, error flag and run-time word register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_addr <= BASE_ALIGNED;
            r_word_cnt  <= '0;
            r_addr_wrap <= 1'b0;
            r_load_err  <= 1'b0;
            r_wr_word   <= '0;
            r_uart_in   <= '0;
            r_uart_in_v <= 1'b0;
        end else begin
            r_uart_in_v <= 1'b0;
            unique case (r_state)
                LOAD_LO: begin
                    if (w_word_v && !w_is_end) begin
                        if (r_addr_wrap) begin
                            r_load_err <= 1'b1;
                        end else begin
                            r_wr_word <= w_word;
                        end
                    end
                end
                WRITE: begin
                    r_load_addr <= r_load_addr + ADDR_W'(2);
                    r_word_cnt  <= r_word_cnt + (ADDR_W-1)'(1);
                    if (r_load_addr == LAST_ADDR) r_addr_wrap <= 1'b1;
                end
                RUN: begin
                    if (w_is_reload) begin
                        r_load_addr <= BASE_ALIGNED;
                        r_word_cnt  <= '0;
                        r_addr_wrap <= 1'b0;
                    end else if (w_word_v) begin
                        r_uart_in   <= w_word;
                        r_uart_in_v <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: memory port mux and CPU reset, decoded from state only.
    always_comb begin
        mem_addr    = r_load_addr;
        mem_wr      = (r_state == WRITE);
        mem_byt     = 1'b0;
        mem_wr_data = r_wr_word;
        cpu_rst     = 1'b1;
        if (r_state == RUN) begin
            mem_addr    = cpu_mem_addr;
            mem_wr      = cpu_mem_wr;
            mem_byt     = cpu_mem_byt;
            mem_wr_data = cpu_wr_data;
            cpu_rst     = 1'b0;
        end
    end

    assign uart_in   = r_uart_in;
    assign uart_in_v = r_uart_in_v;
    assign load_err  = r_load_err;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_prog_loader_arb.sv
// ----------------------------------------------------------------------------
// tb_prog_loader_arb
// Directed bench for prog_loader_arb. Two instances: A at the default load
// base, B near the top of memory for the wrap case. Expected memory writes and
// run-time words are queued when their last byte is driven and popped by
// negedge monitors when the DUT produces them, including the cycle number.
// ----------------------------------------------------------------------------
module tb_prog_loader_arb;

    localparam int unsigned TMO = 20;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_exp_t;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } uart_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_a, rx_b;
    logic        rx_wr_a, rx_wr_b;
    logic [11:0] cpu_addr;
    logic        cpu_wr, cpu_byt;
    logic [15:0] cpu_data;

    logic [11:0] mem_addr_a, mem_addr_b;
    logic        mem_wr_a, mem_wr_b, mem_byt_a, mem_byt_b;
    logic [15:0] mem_wr_data_a, mem_wr_data_b;
    logic        cpu_rst_a, cpu_rst_b;
    logic [15:0] uart_in_a, uart_in_b;
    logic        uart_in_v_a, uart_in_v_b;
    logic        load_err_a, load_err_b;
    logic [10:0] word_cnt_a, word_cnt_b;

    wr_exp_t   q_a[$];
    wr_exp_t   q_b[$];
    uart_exp_t q_u[$];

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prog_loader_arb #(
        .ADDR_W      (12),
        .LOAD_BASE   (12'h300),
        .TIMEOUT_CYC (TMO)
    ) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_a),
        .rx_data_wr   (rx_wr_a),
        .cpu_mem_addr (cpu_addr),
        .cpu_mem_wr   (cpu_wr),
        .cpu_mem_byt  (cpu_byt),
        .cpu_wr_data  (cpu_data),
        .mem_addr     (mem_addr_a),
        .mem_wr       (mem_wr_a),
        .mem_byt      (mem_byt_a),
        .mem_wr_data  (mem_wr_data_a),
        .cpu_rst      (cpu_rst_a),
        .uart_in      (uart_in_a),
        .uart_in_v    (uart_in_v_a),
        .load_err     (load_err_a),
        .word_cnt     (word_cnt_a)
    );

    prog_loader_arb #(
        .ADDR_W      (12),
        .LOAD_BASE   (12'hFFC),
        .TIMEOUT_CYC (TMO)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_b),
        .rx_data_wr   (rx_wr_b),
        .cpu_mem_addr (cpu_addr),
        .cpu_mem_wr   (cpu_wr),
        .cpu_mem_byt  (cpu_byt),
        .cpu_wr_data  (cpu_data),
        .mem_addr     (mem_addr_b),
        .mem_wr       (mem_wr_b),
        .mem_byt      (mem_byt_b),
        .mem_wr_data  (mem_wr_data_b),
        .cpu_rst      (cpu_rst_b),
        .uart_in      (uart_in_b),
        .uart_in_v    (uart_in_v_b),
        .load_err     (load_err_b),
        .word_cnt     (word_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit to_b, input logic [7:0] b);
        if (to_b) begin
            rx_b    = b;
            rx_wr_b = 1'b1;
        end else begin
            rx_a    = b;
            rx_wr_a = 1'b1;
        end
        tick(1);
        rx_wr_a = 1'b0;
        rx_wr_b = 1'b0;
    endtask

    // Call immediately before sending the byte that completes the word.
    task automatic expect_wr(input bit to_b, input logic [11:0] addr, input logic [15:0] data);
        wr_exp_t e;
        e.addr = addr;
        e.data = data;
        e.cyc  = cyc + 1;
        if (to_b) q_b.push_back(e);
        else      q_a.push_back(e);
    endtask

    task automatic expect_uart(input logic [15:0] data);
        uart_exp_t e;
        e.data = data;
        e.cyc  = cyc + 1;
        q_u.push_back(e);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        wr_exp_t   ea;
        wr_exp_t   eb;
        uart_exp_t eu;
        if (mem_wr_a && cpu_rst_a) begin
            if (q_a.size() == 0) begin
                check("a_wr_unexpected", 32'(mem_wr_a), 32'd0);
            end else begin
                ea = q_a.pop_front();
                check("a_wr_addr", 32'(mem_addr_a), 32'(ea.addr));
                check("a_wr_data", 32'(mem_wr_data_a), 32'(ea.data));
                check("a_wr_cyc", 32'(cyc), 32'(ea.cyc));
                check("a_wr_byt", 32'(mem_byt_a), 32'd0);
            end
        end
        if (!cpu_rst_a) begin
            check("a_run_wr", 32'(mem_wr_a), 32'(cpu_wr));
            check("a_run_addr", 32'(mem_addr_a), 32'(cpu_addr));
        end
        if (uart_in_v_a) begin
            if (q_u.size() == 0) begin
                check("a_uart_unexpected", 32'(uart_in_v_a), 32'd0);
            end else begin
                eu = q_u.pop_front();
                check("a_uart_data", 32'(uart_in_a), 32'(eu.data));
                check("a_uart_cyc", 32'(cyc), 32'(eu.cyc));
            end
        end
        if (mem_wr_b) begin
            if (q_b.size() == 0) begin
                check("b_wr_unexpected", 32'(mem_wr_b), 32'd0);
            end else begin
                eb = q_b.pop_front();
                check("b_wr_addr", 32'(mem_addr_b), 32'(eb.addr));
                check("b_wr_data", 32'(mem_wr_data_b), 32'(eb.data));
                check("b_wr_cyc", 32'(cyc), 32'(eb.cyc));
                check("b_wr_byt", 32'(mem_byt_b), 32'd0);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        rx_a     = 8'h00;
        rx_b     = 8'h00;
        rx_wr_a  = 1'b0;
        rx_wr_b  = 1'b0;
        cpu_addr = 12'h000;
        cpu_wr   = 1'b0;
        cpu_byt  = 1'b0;
        cpu_data = 16'h0000;
        tick(2);
        rst = 1'b0;

        // Reset state
        check("rst_cpu_rst", 32'(cpu_rst_a), 32'd1);
        check("rst_mem_wr", 32'(mem_wr_a), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_a), 32'h300);
        check("rst_word_cnt", 32'(word_cnt_a), 32'd0);
        check("rst_load_err", 32'(load_err_a), 32'd0);
        check("rst_uart_in", 32'(uart_in_a), 32'd0);
        check("rst_uart_v", 32'(uart_in_v_a), 32'd0);
        check("rst_b_mem_addr", 32'(mem_addr_b), 32'hFFC);

        // Basic load, back-to-back bytes (next high byte lands in WRITE)
        send(0, 8'h12);
        expect_wr(0, 12'h300, 16'h1234);
        send(0, 8'h34);
        send(0, 8'h56);
        expect_wr(0, 12'h302, 16'h5678);
        send(0, 8'h78);
        send(0, 8'hFF);
        check("load_cpu_rst_held", 32'(cpu_rst_a), 32'd1);
        send(0, 8'hFF);
        check("load_cpu_rst_released", 32'(cpu_rst_a), 32'd0);
        check("load_word_cnt", 32'(word_cnt_a), 32'd2);

        // Run-time pass-through of the CPU request
        cpu_addr = 12'h123;
        cpu_wr   = 1'b1;
        cpu_byt  = 1'b1;
        cpu_data = 16'hBEEF;
        #1;
        check("pass_addr", 32'(mem_addr_a), 32'h123);
        check("pass_wr", 32'(mem_wr_a), 32'd1);
        check("pass_byt", 32'(mem_byt_a), 32'd1);
        check("pass_data", 32'(mem_wr_data_a), 32'hBEEF);
        tick(1);
        cpu_wr  = 1'b0;
        cpu_byt = 1'b0;

        // Run-time word to the CPU
        send(0, 8'hAB);
        expect_uart(16'hABCD);
        send(0, 8'hCD);
        tick(3);
        check("run_uart_in", 32'(uart_in_a), 32'hABCD);
        check("run_uart_v_low", 32'(uart_in_v_a), 32'd0);

        // Reload request, then a fresh load from the base
        send(0, 8'hFF);
        send(0, 8'hFE);
        check("reload_cpu_rst", 32'(cpu_rst_a), 32'd1);
        check("reload_uart_v", 32'(uart_in_v_a), 32'd0);
        check("reload_uart_kept", 32'(uart_in_a), 32'hABCD);
        check("reload_word_cnt", 32'(word_cnt_a), 32'd0);
        check("reload_addr", 32'(mem_addr_a), 32'h300);
        send(0, 8'h00);
        expect_wr(0, 12'h300, 16'h0001);
        send(0, 8'h01);
        send(0, 8'hFF);
        send(0, 8'hFF);
        check("reload_run", 32'(cpu_rst_a), 32'd0);
        check("reload_cnt1", 32'(word_cnt_a), 32'd1);

        // Timeout: stale high byte dropped; a pair just inside the limit kept
        send(0, 8'hFF);
        send(0, 8'hFE);
        send(0, 8'h12);
        tick(TMO + 3);
        send(0, 8'h34);
        tick(TMO - 3);
        expect_wr(0, 12'h300, 16'h3456);
        send(0, 8'h56);
        send(0, 8'hFF);
        send(0, 8'hFF);
        check("tmo_run", 32'(cpu_rst_a), 32'd0);
        check("tmo_cnt", 32'(word_cnt_a), 32'd1);

        // Reset with a high byte pending
        send(0, 8'hFF);
        send(0, 8'hFE);
        send(0, 8'h77);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rstlo_cnt", 32'(word_cnt_a), 32'd0);
        check("rstlo_err", 32'(load_err_a), 32'd0);
        check("rstlo_cpu_rst", 32'(cpu_rst_a), 32'd1);
        send(0, 8'h9A);
        expect_wr(0, 12'h300, 16'h9ABC);
        send(0, 8'hBC);
        send(0, 8'h11);
        check("rstlo_cnt1", 32'(word_cnt_a), 32'd1);
        expect_wr(0, 12'h302, 16'h1122);

        // Reset during WRITE: the write happens, address/count do not advance
        send(0, 8'h22);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rstwr_addr", 32'(mem_addr_a), 32'h300);
        check("rstwr_cnt", 32'(word_cnt_a), 32'd0);

        // Address wrap on instance B
        send(1, 8'h01);
        expect_wr(1, 12'hFFC, 16'h0102);
        send(1, 8'h02);
        send(1, 8'h03);
        expect_wr(1, 12'hFFE, 16'h0304);
        send(1, 8'h04);
        check("wrap_err_before", 32'(load_err_b), 32'd0);
        send(1, 8'h05);
        send(1, 8'h06);
        tick(2);
        check("wrap_err", 32'(load_err_b), 32'd1);
        check("wrap_cnt", 32'(word_cnt_b), 32'd2);
        check("wrap_addr", 32'(mem_addr_b), 32'h000);
        check("wrap_cpu_rst", 32'(cpu_rst_b), 32'd1);
        check("wrap_b_uart", 32'(uart_in_b), 32'd0);
        check("wrap_b_uart_v", 32'(uart_in_v_b), 32'd0);
        check("a_err_clear", 32'(load_err_a), 32'd0);

        tick(3);
        check("a_wr_outstanding", 32'(q_a.size()), 32'd0);
        check("b_wr_outstanding", 32'(q_b.size()), 32'd0);
        check("uart_outstanding", 32'(q_u.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader_arb.md
PROG_LOADER_ARB -- requirements
Module: prog_loader_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default `ADDR_WIDTH (12), memory byte-address width.
REQ-002 SHALL have parameter LOAD_BASE, default 12'h300, first program word address.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 270000 (10 ms at 27 MHz), inter-byte resync timeout.
REQ-004 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port rx_data  in  8  received UART byte.
REQ-007 SHALL have port rx_data_wr  in  1  one-cycle strobe, rx_data valid.
REQ-008 SHALL have ports cpu_mem_addr (in ADDR_W), cpu_mem_wr (in 1), cpu_mem_byt (in 1), cpu_wr_data (in 16), the CPU memory request.
REQ-009 SHALL have ports mem_addr (out ADDR_W), mem_wr (out 1), mem_byt (out 1), mem_wr_data (out 16), the arbitrated memory port.
REQ-010 SHALL have port cpu_rst  out  1  holds CPU in reset while loading.
REQ-011 SHALL have ports uart_in (out 16) and uart_in_v (out 1): run-time received word and its one-cycle valid strobe.
REQ-012 SHALL have ports load_err (out 1, sticky overflow) and word_cnt (out ADDR_W-1, words written this load).

Function
REQ-013 SHALL implement states LOAD_HI, LOAD_LO, WRITE, RUN.
REQ-014 LOAD_HI: rx_data_wr -> latch high byte, next LOAD_LO.
REQ-015 LOAD_LO: rx_data_wr -> form word {hi, lo}; 16'hFFFF -> RUN (no write); else -> WRITE.
REQ-016 WRITE lasts exactly one cycle: mem_wr=1, mem_byt=0, mem_addr=load_addr, mem_wr_data=word; next cycle load_addr+=2, word_cnt+=1, state LOAD_HI.
REQ-017 Latency: low-byte strobe at cycle M -> mem_wr high in cycle M+1.
REQ-018 rx_data_wr coincident with WRITE SHALL be taken as the next high byte (next state LOAD_LO, address still incremented).
REQ-019 In LOAD_HI/LOAD_LO/WRITE, memory port SHALL be driven by the loader only; mem_wr=0 outside WRITE; CPU request ignored.
REQ-020 In RUN, mem_* SHALL equal cpu_mem_* combinationally, zero latency.
REQ-021 cpu_rst SHALL be 1 in every state except RUN, combinationally from state.
REQ-022 RUN: bytes pair hi/lo; completed word at cycle M -> uart_in updated and uart_in_v=1 in cycle M+1 only.
REQ-023 RUN: completed word 16'hFFFE SHALL not update uart_in/uart_in_v; next state LOAD_HI, load_addr=LOAD_BASE, word_cnt=0, load_err kept.
REQ-024 Timeout: a pending high byte with no further strobe for TIMEOUT_CYC cycles SHALL be discarded (LOAD_LO->LOAD_HI; RUN phase -> hi); counter restarts on each strobe.
REQ-025 Overflow: data word arriving when load_addr wrapped past max (after writing 12'hFFE) SHALL not be written; load_err set; state LOAD_HI.
REQ-026 Address arithmetic modulo 2^ADDR_W; bit 0 of load_addr always 0.

Reset
REQ-027 On rst: state LOAD_HI, load_addr=LOAD_BASE, word_cnt=0, load_err=0, uart_in=0, uart_in_v=0, byte phase hi, timeout counter 0; hence cpu_rst=1, mem_wr=0.
REQ-028 rst mid-WRITE SHALL suppress that cycle's effect on addr/cnt; a written word is not rolled back.

Structure
REQ-029 State enum typedef, LOAD_BASE, END_WORD 16'hFFFF, RELOAD_WORD 16'hFFFE SHALL live in shared package comproc_pkg.
REQ-030 Byte pairing plus timeout SHALL be sub-module word_assembler (in: byte, strobe, flush; out: word, word_v), shared by load and run modes.

Verification
REQ-031 Bytes 12 34 56 78 FF FF -> writes 0x1234@0x300, 0x5678@0x302; then cpu_rst falls, word_cnt=2.
REQ-032 In RUN, bytes AB CD -> uart_in=0xABCD, uart_in_v single pulse one cycle after second strobe; no mem_wr from loader.
REQ-033 In RUN, bytes FF FE -> cpu_rst rises next cycle; then 00 01 FF FF -> 0x0001@0x300.
REQ-034 Byte 12, idle TIMEOUT_CYC cycles, then 34 56 FF FF -> single write 0x3456@0x300.
REQ-035 LOAD_BASE=12'hFFC: three data words -> writes @0xFFC, 0xFFE, third dropped, load_err=1.
REQ-036 rst asserted in LOAD_LO with high byte pending -> next pair written @0x300, load_err=0.
